// File: rtl/mcu_core_param.sv
// mcu_core_param: parametrised accumulator MCU with valid/ready program load, HALT/resume.
// Optional MCU_SINGLE_STEP_EN adds a step input that gates each FETCH after an EXECUTE.
module mcu_core_param #(
   parameter int DW   = 8,
   parameter int PA_W = 4,
   parameter int DA_W = 4,
   parameter int IW   = DW + 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ld_valid,
   output logic            ld_ready,
   input  logic [IW-1:0]   ld_data,
   input  logic            ld_last,
   input  logic            resume,
`ifdef MCU_SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic            halted,
   output logic [PA_W-1:0] pc_out,
   output logic [DW-1:0]   acc_out,
   output logic [3:0]      sr_out
);
   typedef enum logic [2:0] {LOAD, FETCH, DECODE, EXECUTE, HALT} state_t;
   state_t state;
   logic [IW-1:0] pmem [2**PA_W];
   logic [DW-1:0] dmem [2**DA_W];
   logic [PA_W-1:0] pc, load_addr;
   logic [IW-1:0] ir;
   logic [DW-1:0] acc, dr, imm, b, res;
   logic [3:0] sr, op;
   logic [DW:0] sum;
   logic c, o, upd, accept, go;
   assign op       = ir[IW-1:IW-4];
   assign imm      = ir[DW-1:0];
   assign ld_ready = state == LOAD;
   assign halted   = state == HALT;
   assign pc_out   = pc;
   assign acc_out  = acc;
   assign sr_out   = sr;
   assign accept   = ld_valid && ld_ready;
`ifdef MCU_SINGLE_STEP_EN
   logic hold;
   always_ff @(posedge clk)
      hold <= !rst && (state == EXECUTE ? op != 4'h1 : state == FETCH && hold && !step);
   assign go = !hold || step;
`else
   assign go = 1'b1;
`endif
   assign b   = op == 4'hD ? imm : dr;
   assign sum = op == 4'h9 ? {1'b0, acc} - {1'b0, dr} : {1'b0, acc} + {1'b0, b};
   assign upd = op == 4'h5 || op == 4'h6 || op >= 4'h8;
   always_comb begin
      res = acc;
      c = 1'b0;
      o = 1'b0;
      case (op)
         4'h5: res = imm;
         4'h6: res = dr;
         4'h8, 4'hD: begin
            res = sum[DW-1:0];
            c = sum[DW];
            o = acc[DW-1] == b[DW-1] && res[DW-1] != acc[DW-1];
         end
         4'h9: begin
            res = sum[DW-1:0];
            c = sum[DW];
            o = acc[DW-1] != dr[DW-1] && res[DW-1] != acc[DW-1];
         end
         4'hA: res = acc & dr;
         4'hB: res = acc | dr;
         4'hC: res = acc ^ dr;
         4'hE: begin
            res = {acc[DW-2:0], 1'b0};
            c = acc[DW-1];
         end
         4'hF: begin
            res = {1'b0, acc[DW-1:1]};
            c = acc[0];
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (accept) pmem[load_addr] <= ld_data;
      if (state == EXECUTE && op == 4'h7) dmem[imm[DA_W-1:0]] <= acc;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
         load_addr <= '0;
         pc <= '0;
         acc <= '0;
         sr <= '0;
         ir <= '0;
         dr <= '0;
      end else begin
         case (state)
            LOAD: if (accept) begin
               load_addr <= load_addr + PA_W'(1);
               if (ld_last || load_addr == '1) begin
                  state <= FETCH;
                  pc <= '0;
                  acc <= '0;
                  sr <= '0;
                  ir <= '0;
                  dr <= '0;
               end
            end
            FETCH: if (go) begin
               ir <= pmem[pc];
               state <= DECODE;
            end
            DECODE: begin
               dr <= dmem[imm[DA_W-1:0]];
               state <= EXECUTE;
            end
            EXECUTE: begin
               state <= op == 4'h1 ? HALT : FETCH;
               if (upd) begin
                  acc <= res;
                  sr <= {res == '0, c, res[DW-1], o};
               end
               case (op)
                  4'h1: ;
                  4'h2: pc <= imm[PA_W-1:0];
                  4'h3: pc <= sr[3] ? imm[PA_W-1:0] : pc + PA_W'(1);
                  4'h4: pc <= sr[2] ? imm[PA_W-1:0] : pc + PA_W'(1);
                  default: pc <= pc + PA_W'(1);
               endcase
            end
            HALT: if (resume) begin
               state <= FETCH;
               pc <= '0;
               acc <= '0;
               sr <= '0;
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_mcu_core_param.sv
// tb_mcu_core_param: directed self-checking bench for mcu_core_param (DW=8, PA_W=4, DA_W=4).
module tb_mcu_core_param;
   logic clk = 0, rst = 1, ld_valid = 0, ld_last = 0, resume = 0;
   logic [11:0] ld_data = '0;
   logic ld_ready, halted;
   logic [3:0] pc_out, sr_out;
   logic [7:0] acc_out;
   logic [11:0] prog [16];
   int errors = 0, checks = 0, cyc;
   mcu_core_param dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .ld_last(ld_last), .resume(resume), .halted(halted), .pc_out(pc_out),
      .acc_out(acc_out), .sr_out(sr_out)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1;
      tick();
      rst = 0;
   endtask
   task automatic load(input int n, input bit use_last, input bit gap);
      for (int i = 0; i < n; i++) begin
         if (gap && i > 0) tick();
         ld_valid = 1;
         ld_data = prog[i];
         ld_last = use_last && i == n - 1;
         tick();
         ld_valid = 0;
         ld_last = 0;
      end
   endtask
   task automatic run_to_halt(input string tag);
      cyc = 0;
      while (!halted && cyc < 200) begin
         tick();
         cyc++;
      end
      check(tag, halted, 1);
   endtask
   function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] imm);
      return {op, imm};
   endfunction
   initial begin
      do_reset();
      check("rst_ready", ld_ready, 1);
      check("rst_halted", halted, 0);
      check("rst_pc", pc_out, 0);
      check("rst_acc", acc_out, 0);
      check("rst_sr", sr_out, 0);
      // overflow into sign: 0x7F + 1
      prog[0] = ins(4'h5, 8'h7F);
      prog[1] = ins(4'hD, 8'h01);
      prog[2] = ins(4'h1, 8'h00);
      load(3, 1, 1);
      check("load_ready_drop", ld_ready, 0);
      check("load_pc", pc_out, 0);
      check("load_acc", acc_out, 0);
      run_to_halt("ovf_halt");
      check("ovf_latency", cyc <= 11, 1);
      check("ovf_acc", acc_out, 8'h80);
      check("ovf_sr", sr_out, 4'b0011);
      check("ovf_pc", pc_out, 2);
      ld_valid = 1;
      tick();
      ld_valid = 0;
      check("halt_ignores_ld", halted, 1);
      resume = 1;
      tick();
      resume = 0;
      check("resume_halted", halted, 0);
      check("resume_pc", pc_out, 0);
      check("resume_acc", acc_out, 0);
      check("resume_sr", sr_out, 0);
      run_to_halt("rerun_halt");
      check("rerun_acc", acc_out, 8'h80);
      check("rerun_sr", sr_out, 4'b0011);
      // carry/zero then taken JZ skipping two LDIs
      do_reset();
      prog[0] = ins(4'h5, 8'hFF);
      prog[1] = ins(4'hD, 8'h01);
      prog[2] = ins(4'h3, 8'h05);
      prog[3] = ins(4'h5, 8'h11);
      prog[4] = ins(4'h5, 8'h11);
      prog[5] = ins(4'h1, 8'h00);
      load(6, 1, 0);
      run_to_halt("jz_halt");
      check("jz_pc", pc_out, 5);
      check("jz_acc", acc_out, 8'h00);
      check("jz_sr", sr_out, 4'b1100);
      // store/load round trip then self-subtract
      do_reset();
      prog[0] = ins(4'h5, 8'h3C);
      prog[1] = ins(4'h7, 8'h02);
      prog[2] = ins(4'h5, 8'h00);
      prog[3] = ins(4'h6, 8'h02);
      prog[4] = ins(4'h9, 8'h02);
      prog[5] = ins(4'h1, 8'h00);
      load(6, 1, 0);
      run_to_halt("mem_halt");
      check("mem_acc", acc_out, 8'h00);
      check("mem_sr", sr_out, 4'b1000);
      // borrow: 0 - 1
      do_reset();
      prog[0] = ins(4'h5, 8'h01);
      prog[1] = ins(4'h7, 8'h00);
      prog[2] = ins(4'h5, 8'h00);
      prog[3] = ins(4'h9, 8'h00);
      prog[4] = ins(4'h1, 8'h00);
      load(5, 1, 0);
      run_to_halt("sub_halt");
      check("sub_acc", acc_out, 8'hFF);
      check("sub_sr", sr_out, 4'b0110);
      // logical shift right drops bit 0 into C
      do_reset();
      prog[0] = ins(4'h5, 8'h81);
      prog[1] = ins(4'hF, 8'h00);
      prog[2] = ins(4'h1, 8'h00);
      load(3, 1, 0);
      run_to_halt("shr_halt");
      check("shr_acc", acc_out, 8'h40);
      check("shr_sr", sr_out, 4'b0100);
      // full-depth load with no ld_last, NOPs wrap PC
      do_reset();
      for (int i = 0; i < 16; i++) prog[i] = ins(4'h0, 8'h00);
      load(15, 0, 0);
      check("full_ready_15", ld_ready, 1);
      ld_valid = 1;
      ld_data = prog[15];
      tick();
      ld_valid = 0;
      check("full_ready_drop", ld_ready, 0);
      for (int i = 0; i < 45; i++) tick();
      check("wrap_pc15", pc_out, 15);
      for (int i = 0; i < 3; i++) tick();
      check("wrap_pc0", pc_out, 0);
      // reset during EXECUTE
      do_reset();
      prog[0] = ins(4'h5, 8'h55);
      prog[1] = ins(4'h0, 8'h00);
      prog[2] = ins(4'h0, 8'h00);
      prog[3] = ins(4'h1, 8'h00);
      load(4, 1, 0);
      for (int i = 0; i < 5; i++) tick();
      check("pre_rst_acc", acc_out, 8'h55);
      do_reset();
      check("mid_rst_ready", ld_ready, 1);
      check("mid_rst_acc", acc_out, 0);
      check("mid_rst_pc", pc_out, 0);
      check("mid_rst_sr", sr_out, 0);
      check("mid_rst_halted", halted, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
